// File: rtl/alu_seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
// The bench drives through the master modport; the divider uses the slave modport.
interface alu_seq_divider_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/alu_seq_divider.sv
// Restoring divider, one trial subtraction per clock over WIDTH iterations.
// Define DIV_SIGNED_EN for two's-complement operands (adds the FIX sign-correction state).
module alu_seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   alu_seq_divider_if.slave   bus
);
   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
`ifdef DIV_SIGNED_EN
   localparam logic [1:0] S_FIX  = 2'd2;
`endif
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       r_state;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_dvs;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic             r_dbz;

   logic             w_accept;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;
   logic             w_borrow;
   logic [WIDTH:0]   w_rem_next;
   logic [WIDTH-1:0] w_q_next;
   logic             w_last;
   logic [WIDTH-1:0] w_dvd_in;
   logic [WIDTH-1:0] w_dvs_in;

   assign w_accept   = bus.start && (r_state == S_IDLE || r_state == S_DONE);
   // The dividend register doubles as the quotient: its MSB feeds the remainder, quotient bits enter at the LSB.
   assign w_shift    = (r_rem << 1) | {{WIDTH{1'b0}}, r_dvd[WIDTH-1]};
   assign w_trial    = w_shift - {1'b0, r_dvs};
   assign w_borrow   = w_trial[WIDTH];
   assign w_rem_next = w_borrow ? w_shift : w_trial;
   assign w_q_next   = {r_dvd[WIDTH-2:0], ~w_borrow};
   assign w_last     = (r_cnt == CW'(WIDTH - 1));

`ifdef DIV_SIGNED_EN
   logic r_neg_q;
   logic r_neg_r;

   assign w_dvd_in = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
   assign w_dvs_in = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (w_accept) begin
         r_neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
         r_neg_r <= bus.dividend[WIDTH-1];
      end
   end
`else
   assign w_dvd_in = bus.dividend;
   assign w_dvs_in = bus.divisor;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_rem   <= '0;
         r_dvd   <= '0;
         r_dvs   <= '0;
         r_cnt   <= '0;
         r_q     <= '0;
         r_r     <= '0;
         r_dbz   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_dvd <= w_dvd_in;
                  r_dvs <= w_dvs_in;
                  r_rem <= '0;
                  r_cnt <= '0;
                  if (bus.divisor == '0) begin
                     r_q     <= '1;
                     r_r     <= bus.dividend;
                     r_dbz   <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_dbz   <= 1'b0;
                     r_state <= S_RUN;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               r_rem <= w_rem_next;
               r_dvd <= w_q_next;
               r_cnt <= r_cnt + CW'(1);
               if (w_last) begin
`ifdef DIV_SIGNED_EN
                  r_state <= S_FIX;
`else
                  r_q     <= w_q_next;
                  r_r     <= w_rem_next[WIDTH-1:0];
                  r_state <= S_DONE;
`endif
               end
            end
`ifdef DIV_SIGNED_EN
            S_FIX: begin
               // Magnitudes are final here; apply signs while publishing so outputs change once.
               r_q     <= r_neg_q ? -r_dvd : r_dvd;
               r_r     <= r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
               r_state <= S_DONE;
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef DIV_SIGNED_EN
   assign bus.busy = (r_state == S_RUN) || (r_state == S_FIX);
`else
   assign bus.busy = (r_state == S_RUN);
`endif
   assign bus.done        = (r_state == S_DONE);
   assign bus.quotient    = r_q;
   assign bus.remainder   = r_r;
   assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_alu_seq_divider.sv
// Self-checking bench for alu_seq_divider: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results. Signed vectors run when DIV_SIGNED_EN is defined.
module tb_alu_seq_divider;
   localparam int W = 32;
`ifdef DIV_SIGNED_EN
   localparam int LAT = W + 1;
`else
   localparam int LAT = W;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   bit   cmp_en = 1'b0;

   alu_seq_divider_if #(.WIDTH(W)) bus ();

   alu_seq_divider #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain arithmetic on the operands, result published a fixed number of edges later.
   function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] q, output logic [W-1:0] r);
`ifdef DIV_SIGNED_EN
      logic signed [W-1:0] sa, sb;
      sa = a;
      sb = b;
      if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
         q = a;
         r = '0;
      end else begin
         q = sa / sb;
         r = sa % sb;
      end
`else
      q = a / b;
      r = a % b;
`endif
   endfunction

   bit             m_busy = 1'b0;
   bit             m_done = 1'b0;
   int             m_left = 0;
   logic [W-1:0]   m_q = '0, m_r = '0, p_q = '0, p_r = '0;
   logic           m_dbz = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_left = 0;
         m_q    = '0;
         m_r    = '0;
         m_dbz  = 1'b0;
      end else begin
         cyc++;
         m_done = 1'b0;
         if (bus.start && !m_busy) begin
            m_dbz = 1'b0;
            if (bus.divisor == '0) begin
               m_q    = '1;
               m_r    = bus.dividend;
               m_dbz  = 1'b1;
               m_done = 1'b1;
            end else begin
               ref_div(bus.dividend, bus.divisor, p_q, p_r);
               m_busy = 1'b1;
               m_left = LAT;
            end
         end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               m_q    = p_q;
               m_r    = p_r;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("busy",        {{(W-1){1'b0}}, bus.busy},        {{(W-1){1'b0}}, m_busy});
         check("done",        {{(W-1){1'b0}}, bus.done},        {{(W-1){1'b0}}, m_done});
         check("quotient",    bus.quotient,                     m_q);
         check("remainder",   bus.remainder,                    m_r);
         check("div_by_zero", {{(W-1){1'b0}}, bus.div_by_zero}, {{(W-1){1'b0}}, m_dbz});
      end
   end

   // Caller is positioned away from the edge; start is held across exactly one rising edge.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk);
      #2;
      bus.start = 1'b0;
      acc_cyc   = cyc;
   endtask

   task automatic wait_done(input string name, output int lat);
      lat = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.done) begin
            lat = cyc - acc_cyc;
            return;
         end
      end
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: no done within 200 cycles", name);
   endtask

   task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                         input int elat);
      int lat;
      @(posedge clk);
      #2;
      launch(a, b);
      wait_done(name, lat);
      check({name, " latency"}, W'(lat), W'(elat));
      check({name, " q"},       bus.quotient,  eq);
      check({name, " r"},       bus.remainder, er);
      check({name, " dbz"},     {{(W-1){1'b0}}, bus.div_by_zero}, {{(W-1){1'b0}}, edbz});
   endtask

   initial begin
      int lat;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      cmp_en = 1'b1;
      @(negedge clk);
      check("reset q",    bus.quotient,  '0);
      check("reset r",    bus.remainder, '0);
      check("reset busy", {{(W-1){1'b0}}, bus.busy}, '0);

      // Divide by zero: done right after the accepting edge, busy never rises.
      run_op("5/0",   32'd5,   32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
`ifndef DIV_SIGNED_EN
      run_op("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);
      run_op("0/5",   32'd0,   32'd5, 32'd0,  32'd0, 1'b0, 32);
      run_op("3/max", 32'd3,   32'hFFFF_FFFF, 32'd0, 32'd3, 1'b0, 32);
      run_op("msb/msb", 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 32);

      // Back-to-back: second start issued in the done cycle, mid-run start ignored.
      run_op("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32);
      launch(32'd3, 32'd10);
      repeat (5) @(posedge clk);
      #2;
      bus.start    = 1'b1;
      bus.dividend = 32'd99;
      bus.divisor  = 32'd9;
      @(posedge clk);
      #2;
      bus.start = 1'b0;
      wait_done("3/10", lat);
      check("3/10 latency", W'(lat), 32'd32);
      check("3/10 q", bus.quotient,  32'd0);
      check("3/10 r", bus.remainder, 32'd3);

      // Reset mid-operation: outputs clear and no done follows.
      @(posedge clk);
      #2;
      launch(32'd1000, 32'd3);
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      @(negedge clk);
      check("rst q",    bus.quotient,  '0);
      check("rst r",    bus.remainder, '0);
      check("rst busy", {{(W-1){1'b0}}, bus.busy}, '0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (40) @(posedge clk);
      run_op("20/4", 32'd20, 32'd4, 32'd5, 32'd0, 1'b0, 32);
`else
      run_op("-7/2",  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
      run_op("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
      run_op("7/-2",  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
      run_op("-7/0",  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 0);
      run_op("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
`endif
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
